button_conditioner: RTL and testbench

//  Conditions the raw active-low board buttons before they reach the CPU input port.
//  - Two-flop synchroniser, then a per-button debounce state machine.
//  - Outputs a debounced active-high level plus single-cycle press/release event pulses.
//  - Replaces the bare one-flop inverter in front of the CPU; the CPU polls levels or consumes events.

---
 rtl/button_conditioner_if.sv | 29 ++
 rtl/button_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner_if
// Purpose  : Raw button pads in, debounced levels and press/release events out.
// Revision : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btnRaw;
    logic [NUM_BTN-1:0] btnLevel;
    logic [NUM_BTN-1:0] btnPress;
    logic [NUM_BTN-1:0] btnRelease;

    modport master (
        output btnRaw,
        input  btnLevel,
        input  btnPress,
        input  btnRelease
    );

    modport slave (
        input  btnRaw,
        output btnLevel,
        output btnPress,
        output btnRelease
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise and debounce active-low buttons; emit level + events.
//            Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_PERIOD   = 2700000
) (
    input  wire logic           clk,
    input  wire logic           rstN,
    button_conditioner_if.slave btn
);

    localparam int c_max_ab  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_max_par = (c_max_ab > REPEAT_PERIOD) ? c_max_ab : REPEAT_PERIOD;
    localparam int c_cnt_w   = $clog2(c_max_par + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
    localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [c_cnt_w-1:0] c_rep_last   = c_cnt_w'(REPEAT_DELAY - 1);
    // Reloading here makes the next match land exactly REPEAT_PERIOD cycles later.
    localparam logic [c_cnt_w-1:0] c_rep_reload = c_cnt_w'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } state_e;

    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == c_cnt_max) ? v : v + c_cnt_one;
    endfunction

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync1_d;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] sync2_d;
    logic [NUM_BTN-1:0] w_pressed;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;

    always_comb begin
        sync1_d = btn.btnRaw;
        sync2_d = sync1_q;
    end

    // Synchroniser holds raw pad polarity; reset value 1 means "released".
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign w_pressed = ~sync2_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        state_e               state_q;
        state_e               state_d;
        logic [c_cnt_w-1:0]   cnt_q;
        logic [c_cnt_w-1:0]   cnt_d;
        logic                 level_q;
        logic                 level_d;
        logic                 press_q;
        logic                 press_d;
        logic                 release_q;
        logic                 release_d;

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                state_q   <= S_IDLE;
                cnt_q     <= c_cnt_zero;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;

            case (state_q)
                S_IDLE: begin
                    level_d = 1'b0;
                    cnt_d   = c_cnt_zero;
                    if (w_pressed[i]) begin
                        state_d = S_PRESS_CHK;
                        cnt_d   = c_cnt_one;
                    end
                end

                S_PRESS_CHK: begin
                    if (!w_pressed[i]) begin
                        state_d = S_IDLE;
                        cnt_d   = c_cnt_zero;
                    end else if (cnt_q == c_deb_last) begin
                        state_d = S_HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = c_cnt_zero;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end

                S_HELD: begin
                    level_d = 1'b1;
                    if (!w_pressed[i]) begin
                        state_d = S_REL_CHK;
                        cnt_d   = c_cnt_one;
                    end else begin
`ifdef BTN_AUTOREPEAT_EN
                        if (cnt_q == c_rep_last) begin
                            press_d = 1'b1;
                            cnt_d   = c_rep_reload;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
`else
                        cnt_d = c_cnt_zero;
`endif
                    end
                end

                S_REL_CHK: begin
                    if (w_pressed[i]) begin
                        state_d = S_HELD;
                        cnt_d   = c_cnt_zero;
                    end else if (cnt_q == c_deb_last) begin
                        state_d   = S_IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = c_cnt_zero;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = c_cnt_zero;
                    level_d = 1'b0;
                end
            endcase
        end

        assign w_level[i]   = level_q;
        assign w_press[i]   = press_q;
        assign w_release[i] = release_q;
    end

    assign btn.btnLevel   = w_level;
    assign btn.btnPress   = w_press;
    assign btn.btnRelease = w_release;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed scoreboard bench for button_conditioner (2 buttons, debounce 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int NB  = 2;
    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
    } ev_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   cyc  = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];

    button_conditioner_if #(.NUM_BTN(NB)) bif ();

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .btn  (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check2(string tag, logic [1:0] obs, logic [1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_int(string tag, int obs, int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(int c, logic [1:0] p, logic [1:0] r);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every event pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (rstN && ((bif.btnPress | bif.btnRelease) != 2'b00)) begin
            check2("press_release_overlap", bif.btnPress & bif.btnRelease, 2'b00);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_event: observed press=%b release=%b at cycle %0d expected none",
                       bif.btnPress, bif.btnRelease, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check_int("event_cycle", cyc, e.cyc);
                check2("event_press", bif.btnPress, e.press);
                check2("event_release", bif.btnRelease, e.rel);
            end
        end
    end

    initial begin
        int t;
        bif.btnRaw = 2'b00;
        rstN       = 1'b0;

        // Reset with both buttons pressed, then release reset.
        step(3);
        check2("rst_level", bif.btnLevel, 2'b00);
        check2("rst_press", bif.btnPress, 2'b00);
        check2("rst_release", bif.btnRelease, 2'b00);
        t    = cyc;
        rstN = 1'b1;
        push(t + 10, 2'b11, 2'b00);
        step(9);
        check2("both_level_before", bif.btnLevel, 2'b00);
        step(1);
        check2("both_level_at_10", bif.btnLevel, 2'b11);
        step(2);
        t = cyc;
        bif.btnRaw = 2'b11;
        push(t + 10, 2'b00, 2'b11);
        step(12);
        check2("both_released_level", bif.btnLevel, 2'b00);
        check_int("q_empty_t1", exp_q.size(), 0);

        // Short glitch and fast toggling on btn0.
        bif.btnRaw = 2'b10;
        step(5);
        bif.btnRaw = 2'b11;
        step(15);
        check2("glitch_level", bif.btnLevel, 2'b00);
        for (int k = 0; k < 4; k++) begin
            bif.btnRaw[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        step(15);
        check2("toggle_level", bif.btnLevel, 2'b00);
        check_int("q_empty_t2", exp_q.size(), 0);

        // btn0 held 40 cycles.
        t = cyc;
        bif.btnRaw = 2'b10;
        push(t + 10, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
        push(t + 30, 2'b01, 2'b00);
        push(t + 35, 2'b01, 2'b00);
        push(t + 40, 2'b01, 2'b00);
`endif
        step(20);
        check2("held40_level_mid", bif.btnLevel, 2'b01);
        step(20);
        bif.btnRaw = 2'b11;
        push(t + 50, 2'b00, 2'b01);
        step(9);
        check2("held40_level_before_rel", bif.btnLevel, 2'b01);
        step(6);
        check2("held40_level_after", bif.btnLevel, 2'b00);
        check_int("q_empty_t3", exp_q.size(), 0);

        // btn1 bounces high for 3 cycles while held.
        t = cyc;
        bif.btnRaw = 2'b01;
        push(t + 10, 2'b10, 2'b00);
        step(15);
        bif.btnRaw = 2'b11;
        step(3);
        bif.btnRaw = 2'b01;
        step(7);
        check2("bounce_level_mid", bif.btnLevel, 2'b10);
        step(5);
        check2("bounce_level_after", bif.btnLevel, 2'b10);
        bif.btnRaw = 2'b11;
        push(t + 40, 2'b00, 2'b10);
        step(15);
        check2("bounce_released_level", bif.btnLevel, 2'b00);
        check_int("q_empty_t4", exp_q.size(), 0);

        // Long hold on btn0 (auto-repeat window).
        t = cyc;
        bif.btnRaw = 2'b10;
        push(t + 10, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 6; k++) push(t + 30 + 5 * k, 2'b01, 2'b00);
`endif
        step(56);
        check2("hold56_level", bif.btnLevel, 2'b01);
        bif.btnRaw = 2'b11;
        push(t + 66, 2'b00, 2'b01);
        step(16);
        check2("hold56_released_level", bif.btnLevel, 2'b00);
        check_int("q_empty_t5", exp_q.size(), 0);

        // Reset in the middle of the press check.
        t = cyc;
        bif.btnRaw = 2'b10;
        step(7);
        check2("midchk_level", bif.btnLevel, 2'b00);
        rstN = 1'b0;
        step(1);
        check2("midrst_level", bif.btnLevel, 2'b00);
        check2("midrst_press", bif.btnPress, 2'b00);
        step(1);
        t    = cyc;
        rstN = 1'b1;
        push(t + 10, 2'b01, 2'b00);
        step(9);
        check2("postrst_level_before", bif.btnLevel, 2'b00);
        step(1);
        check2("postrst_level_at_10", bif.btnLevel, 2'b01);
        t = cyc;
        bif.btnRaw = 2'b11;
        push(t + 10, 2'b00, 2'b01);
        step(12);
        check2("postrst_released_level", bif.btnLevel, 2'b00);
        check_int("q_empty_t6", exp_q.size(), 0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
